tap_delay_line: RTL
===================

# tap_delay_line

Parametrised sample delay line for the FIR datapath. It replaces the fixed 64×16 shift-register sample store with a circular buffer. Each accepted input sample becomes tap 0 and ages by one tap per write. The block serves two kinds of read: single random tap reads, and an automatic full-depth scan that streams every tap to the MAC with valid/last framing. Taps older than the number of samples written since reset read as zero, so reset never has to clear storage.

## Interface
- WIDTH, 16, sample width in bits
- DEPTH, 64, number of taps; power of two, ≥ 4
- AW, $clog2(DEPTH), localparam, tap index width
- clk  in  1  clock, rising edge
- R  in  1  reset, asynchronous, active-high
- E  in  1  write enable: push w as new tap 0
- w  in  WIDTH  input sample
- rd  in  1  random read request (IDLE only)
- Addr  in  AW  tap index for rd (0 = newest)
- start  in  1  begin full scan (IDLE only)
- Q  out  WIDTH  registered read data
- Qv  out  1  Q valid
- Qidx  out  AW  tap index of current Q
- Qlast  out  1  final scan output (tap 0)
- busy  out  1  scan in progress
- count  out  AW+1  samples held, saturating at DEPTH
- full  out  1  count == DEPTH

## Operation
- **Storage and count**
  - Write pointer wp. On E: mem[wp] <= w, wp <= wp+1 (wraps mod DEPTH), count <= min(count+1, DEPTH).
  - E is accepted in every state, including during a scan.
- **Tap addressing**
  - Tap k lives at address (wp−1−k) mod DEPTH.
  - Any tap with k ≥ count (or ≥ the count snapshot during a scan) returns 0.
- **FSM: IDLE / SCAN**
  - IDLE, start=1: latch base = next wp and cnt_snap = next count. Both snapshots include a write in the same cycle. Go to SCAN with idx = DEPTH−1.
  - SCAN: issue read of tap idx each cycle, using the snapshot base and cnt_snap. idx decrements each cycle. After issuing idx=0, go to IDLE.
  - Scan order is oldest first, tap DEPTH−1 down to tap 0. Because of this order, concurrent writes only overwrite slots that have already been read. Memory is read-before-write, so a same-cycle read returns the old data.
- **Random read**
  - IDLE, rd=1: read tap Addr using the live wp and count.
  - If start and rd arrive in the same cycle, start wins and rd is dropped.
  - rd or start while busy is ignored.
- **Reset**
  - Outputs: Q=0, Qv=0, Qidx=0, Qlast=0, busy=0, count=0, full=0.
  - Internal state: wp=0, FSM to IDLE. Memory contents are not cleared.
  - Reset during a scan aborts it immediately; no Qlast is produced.

## Timing
- Random read: rd sampled in cycle t → Q, Qv, Qidx valid in cycle t+1 only.
- Scan: start sampled in cycle t.
  - busy is high in cycles t+1 through t+DEPTH+1.
  - Tap DEPTH−1−m appears on Q in cycle t+2+m.
  - Qv is high for DEPTH consecutive cycles.
  - Qlast is high with tap 0 in cycle t+DEPTH+1.
- The earliest accepted next start is in cycle t+DEPTH+1, the Qlast cycle. busy is high in that cycle but the FSM is already in IDLE; this gives back-to-back scans with no gap.
- count and full update the cycle after E.

## Structure
- Shared package fir_pkg holds:
  - default WIDTH and DEPTH constants
  - FSM state typedef (IDLE, SCAN)
- One sub-module, tap_ram: DEPTH×WIDTH, one synchronous write port, one combinational read port.
- Pointer, count, FSM, zero-masking and output registers stay in tap_delay_line.

## Test plan
- Reset, then start with nothing written → 64 cycles of Qv, all Q=0, Qidx 63..0, Qlast with Qidx=0, busy low afterwards.
- Write 1,2,3. Then rd Addr=0 → Q=3; Addr=2 → Q=1; Addr=3 → Q=0. count=3, full=0.
- Write 1..70 → count=64, full=1. Scan → Q=7,8,…,70 with Qidx 63..0, wp wrap exercised.
- Hold E=1 with w=1000+n throughout a scan started after writing 1..64 → scan output is exactly 1..64. Afterwards count=64 and rd Addr=0 returns the last w written.
- start and rd in the same IDLE cycle → scan only, no single-read Qv at t+1. start again mid-scan → ignored. start in the Qlast cycle → second scan follows with no Qv gap.
- Assert R at scan output 10 → Qv, busy and Qlast drop immediately, count=0. A following rd Addr=0 returns 0 despite stale memory.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR sample datapath.
package fir_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/tap_ram.sv
// Tap storage: one synchronous write port, one combinational read port.
// A read of the address being written in the same cycle sees the old word.
module tap_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tap_delay_line.sv
// Circular-buffer sample delay line with random tap reads and a full
// oldest-first scan framed by Qv/Qlast. Taps beyond the number of samples
// written since reset read as zero, so storage is never cleared.
module tap_delay_line
  import fir_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             R,
  input  logic             E,
  input  logic [WIDTH-1:0] w,
  input  logic             rd,
  input  logic [AW-1:0]    Addr,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             Qv,
  output logic [AW-1:0]    Qidx,
  output logic             Qlast,
  output logic             busy,
  output logic [AW:0]      count,
  output logic             full
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  state_t           state, state_nx;
  logic [AW-1:0]    wp, wp_nx;
  logic [AW:0]      count_nx;
  logic [AW-1:0]    base;
  logic [AW:0]      cnt_snap;
  logic [AW-1:0]    idx;

  logic             iss_v;
  logic             iss_last;
  logic [AW-1:0]    iss_idx;
  logic [AW-1:0]    iss_base;
  logic [AW:0]      iss_cnt;
  logic             iss_hit;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign full     = (count == DEPTH_CNT);
  assign wp_nx    = E ? wp + 1'b1 : wp;
  assign count_nx = (E && !full) ? count + 1'b1 : count;

  // The Qlast cycle still reports busy although the FSM is already idle.
  assign busy = (state == SCAN) || Qlast;

  tap_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (E),
    .waddr (wp),
    .wdata (w),
    .raddr (raddr),
    .rdata (rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= state_nx;
  end

  // FSM next state: a scan runs until tap 0 has been issued.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (idx == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: which tap is read this cycle and against which pointer/count.
  always_comb begin
    iss_v    = 1'b0;
    iss_last = 1'b0;
    iss_idx  = Addr;
    iss_base = wp;
    iss_cnt  = count;
    case (state)
      IDLE: begin
        if (rd && !start) iss_v = 1'b1;
      end
      SCAN: begin
        iss_v    = 1'b1;
        iss_idx  = idx;
        iss_base = base;
        iss_cnt  = cnt_snap;
        iss_last = (idx == '0);
      end
      default: ;
    endcase
  end

  assign raddr   = iss_base - AW'(1) - iss_idx;
  assign iss_hit = ({1'b0, iss_idx} < iss_cnt);

  // Write pointer and saturating sample count; writes are accepted in any state.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      wp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp_nx;
      count <= count_nx;
    end
  end

  // Scan snapshot: base and count include a write landing in the start cycle.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      base     <= '0;
      cnt_snap <= '0;
      idx      <= '0;
    end else if (state == IDLE && start) begin
      base     <= wp_nx;
      cnt_snap <= count_nx;
      idx      <= AW'(DEPTH - 1);
    end else if (state == SCAN) begin
      idx      <= idx - 1'b1;
    end
  end

  // Registered read data with zero-masking of taps not yet written.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      Q     <= '0;
      Qv    <= 1'b0;
      Qidx  <= '0;
      Qlast <= 1'b0;
    end else begin
      Qv    <= iss_v;
      Qlast <= iss_last;
      if (iss_v) begin
        Q    <= iss_hit ? rdata : '0;
        Qidx <= iss_idx;
      end
    end
  end

endmodule
